// File: rtl/uart_tx_if.sv
// Byte handshake between a byte source and uart_tx.
// Carries data_in/data_valid/data_ready plus the per-byte frame options.
interface uart_tx_if;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic [1:0] parity_type;
    logic       nstop;

    modport master (
        output data_in,
        output data_valid,
        output parity_type,
        output nstop,
        input  data_ready
    );

    modport slave (
        input  data_in,
        input  data_valid,
        input  parity_type,
        input  nstop,
        output data_ready
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter, 16 clocks per bit, optional parity and 1/2 stop bits.
// Ports: clock, reset (async, high), tx_en, bus (uart_tx_if.slave), txd, tx_done.
// Option: define UART_TX_BUFFER_EN for a one-entry holding buffer.
module uart_tx (
    input  logic      clock,
    input  logic      reset,
    input  logic      tx_en,
    uart_tx_if.slave  bus,
    output logic      txd,
    output logic      tx_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2
    } state_t;

    state_t     state_q;
    logic [3:0] timer_q;
    logic [2:0] cnt_q;
    logic [7:0] byte_q;
    logic [1:0] par_q;
    logic       two_q;
    logic       txd_q;
    logic       done_q;
    // Keeps data_ready low during reset and the first cycle after it.
    logic       live_q;

    logic       xfer;
    logic       bit_end;
    logic       fend;
    logic       go_end;
    logic [7:0] nxt_byte;
    logic [1:0] nxt_par;
    logic       nxt_two;

`ifdef UART_TX_BUFFER_EN
    logic       buf_full_q;
    logic [7:0] buf_byte_q;
    logic [1:0] buf_par_q;
    logic       buf_two_q;

    assign bus.data_ready = tx_en & live_q & ~buf_full_q;
`else
    assign bus.data_ready = tx_en & live_q & (state_q == S_IDLE);
`endif

    assign xfer    = bus.data_valid & bus.data_ready;
    assign bit_end = (timer_q == 4'd15);
    // Last cycle of the final stop bit.
    assign fend    = bit_end &
                     (((state_q == S_STOP1) & ~two_q) |
                      (state_q == S_STOP2));

    // Source of the frame that follows the current one without a gap.
    always_comb begin
        nxt_byte = bus.data_in;
        nxt_par  = bus.parity_type;
        nxt_two  = bus.nstop;
        go_end   = 1'b0;
`ifdef UART_TX_BUFFER_EN
        go_end = buf_full_q | xfer;
        if (buf_full_q) begin
            nxt_byte = buf_byte_q;
            nxt_par  = buf_par_q;
            nxt_two  = buf_two_q;
        end
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            timer_q <= 4'd0;
            cnt_q   <= 3'd0;
            byte_q  <= 8'd0;
            par_q   <= 2'd0;
            two_q   <= 1'b0;
            txd_q   <= 1'b1;
            done_q  <= 1'b0;
            live_q  <= 1'b0;
`ifdef UART_TX_BUFFER_EN
            buf_full_q <= 1'b0;
            buf_byte_q <= 8'd0;
            buf_par_q  <= 2'd0;
            buf_two_q  <= 1'b0;
`endif
        end else begin
            live_q  <= 1'b1;
            done_q  <= 1'b0;
            timer_q <= timer_q + 4'd1;
`ifdef UART_TX_BUFFER_EN
            // Mid-frame acceptance parks the byte with its options.
            if (xfer && state_q != S_IDLE && !fend) begin
                buf_full_q <= 1'b1;
                buf_byte_q <= bus.data_in;
                buf_par_q  <= bus.parity_type;
                buf_two_q  <= bus.nstop;
            end
`endif
            unique case (state_q)
                S_IDLE: begin
                    timer_q <= 4'd0;
                    txd_q   <= 1'b1;
                    if (xfer) begin
                        byte_q  <= bus.data_in;
                        par_q   <= bus.parity_type;
                        two_q   <= bus.nstop;
                        txd_q   <= 1'b0;
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        cnt_q   <= 3'd0;
                        txd_q   <= byte_q[0];
                        state_q <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        if (cnt_q == 3'd7) begin
                            if (par_q[1]) begin
                                txd_q   <= (^byte_q) ^ par_q[0];
                                state_q <= S_PARITY;
                            end else begin
                                txd_q   <= 1'b1;
                                state_q <= S_STOP1;
                            end
                        end else begin
                            cnt_q <= cnt_q + 3'd1;
                            txd_q <= byte_q[cnt_q + 3'd1];
                        end
                    end
                end
                S_PARITY: begin
                    if (bit_end) begin
                        txd_q   <= 1'b1;
                        state_q <= S_STOP1;
                    end
                end
                S_STOP1, S_STOP2: begin
                    if (bit_end && state_q == S_STOP1 && two_q) begin
                        state_q <= S_STOP2;
                    end
                    if (fend) begin
                        done_q <= 1'b1;
                        if (go_end) begin
                            byte_q  <= nxt_byte;
                            par_q   <= nxt_par;
                            two_q   <= nxt_two;
                            txd_q   <= 1'b0;
                            state_q <= S_START;
`ifdef UART_TX_BUFFER_EN
                            buf_full_q <= 1'b0;
`endif
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: begin
                    txd_q   <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign txd     = txd_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: frame shapes, parity, stop bits, reset, tx_en.
// Define UART_TX_BUFFER_EN for both RTL and bench to exercise the buffer.
module tb_uart_tx;

    logic clock = 1'b0;
    logic reset;
    logic tx_en;
    logic txd;
    logic tx_done;

    uart_tx_if bus ();

    uart_tx dut (
        .clock   (clock),
        .reset   (reset),
        .tx_en   (tx_en),
        .bus     (bus),
        .txd     (txd),
        .tx_done (tx_done)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic offer(input logic [7:0] b, input logic [1:0] pt,
                         input logic ns);
        int w;
        w = 0;
        @(negedge clock);
        while (!bus.data_ready && w < 40) begin
            @(negedge clock);
            w++;
        end
        check("offer_rdy", bus.data_ready, 1);
        bus.data_in     = b;
        bus.parity_type = pt;
        bus.nstop       = ns;
        bus.data_valid  = 1'b1;
        @(posedge clock);
        #1 bus.data_valid = 1'b0;
    endtask

    // mode 0 plain, 1 change inputs mid-frame, 2 drop tx_en,
    // 3 offer a second byte early in the frame.
    task automatic capture(input logic [7:0] b, input logic [1:0] pt,
                           input logic ns, input logic pbit,
                           input string tag, input int mode,
                           input int c0);
        logic [11:0] fr;
        int len, errs, rdy, done_at;
        len  = 16 * (10 + int'(pt[1]) + int'(ns));
        errs = 0;
        rdy  = 0;
        done_at = 0;
        fr = '1;
        fr[0]   = 1'b0;
        fr[8:1] = b;
        if (pt[1]) fr[9] = pbit;
        for (int c = c0; c <= len + 20; c++) begin
            @(negedge clock);
            if (tx_done) begin
                done_at = c;
                break;
            end
            if (c <= len) begin
                if (txd !== fr[(c - 1) / 16]) errs++;
                if (bus.data_ready) rdy++;
            end
            if (mode == 1 && c == 80) begin
                bus.parity_type = 2'd0;
                bus.nstop       = 1'b0;
                bus.data_in     = 8'h00;
            end
            if (mode == 2 && c == 20) begin
                tx_en           = 1'b0;
                bus.data_in     = 8'h99;
                bus.parity_type = 2'd0;
                bus.nstop       = 1'b0;
                bus.data_valid  = 1'b1;
            end
            if (mode == 3 && c == 5) begin
                bus.data_in     = 8'h34;
                bus.parity_type = 2'd0;
                bus.nstop       = 1'b0;
                bus.data_valid  = 1'b1;
            end
            if (mode == 3 && c == 6) bus.data_valid = 1'b0;
        end
        check({tag, "_bits"}, errs, 0);
        check({tag, "_done_at"}, done_at, len + 1);
`ifndef UART_TX_BUFFER_EN
        check({tag, "_rdy_busy"}, rdy, 0);
`endif
        if (mode != 3) begin
            check({tag, "_done_txd"}, txd, 1);
            @(negedge clock);
            check({tag, "_pulse"}, tx_done, 0);
        end
    endtask

    initial begin
        int cnt;
        reset           = 1'b1;
        tx_en           = 1'b1;
        bus.data_valid  = 1'b0;
        bus.data_in     = 8'h00;
        bus.parity_type = 2'd0;
        bus.nstop       = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_txd", txd, 1);
        check("rst_done", tx_done, 0);
        check("rst_rdy", bus.data_ready, 0);
        reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("rel_rdy", bus.data_ready, 1);
        tx_en = 1'b0;
        #1 check("rdy_follow_en", bus.data_ready, 0);
        tx_en = 1'b1;

        offer(8'h55, 2'd0, 1'b0);
        capture(8'h55, 2'd0, 1'b0, 1'b0, "f55", 0, 1);

        offer(8'hA3, 2'd2, 1'b0);
        capture(8'hA3, 2'd2, 1'b0, 1'b0, "fA3e", 0, 1);

        offer(8'hA3, 2'd3, 1'b0);
        capture(8'hA3, 2'd3, 1'b0, 1'b1, "fA3o", 0, 1);

        offer(8'h0F, 2'd3, 1'b1);
        capture(8'h0F, 2'd3, 1'b1, 1'b1, "f0F", 1, 1);

        // Reset in the middle of a 0x00 frame.
        offer(8'h00, 2'd0, 1'b0);
        repeat (50) @(negedge clock);
        check("mid_txd", txd, 0);
        reset = 1'b1;
        #1;
        check("mid_rst_txd", txd, 1);
        check("mid_rst_rdy", bus.data_ready, 0);
        @(negedge clock);
        reset = 1'b0;
        cnt = 0;
        repeat (200) begin
            @(negedge clock);
            if (tx_done || !txd) cnt++;
        end
        check("mid_rst_quiet", cnt, 0);
        offer(8'hC6, 2'd1, 1'b0);
        capture(8'hC6, 2'd1, 1'b0, 1'b0, "fC6", 0, 1);

        // tx_en drops mid-frame with a byte already waiting.
        offer(8'h3C, 2'd0, 1'b0);
        capture(8'h3C, 2'd0, 1'b0, 1'b0, "f3C", 2, 1);
        cnt = 0;
        repeat (30) begin
            @(negedge clock);
            if (tx_done || !txd || bus.data_ready) cnt++;
        end
        check("en_off_hold", cnt, 0);
        tx_en = 1'b1;
        #1 check("en_on_rdy", bus.data_ready, 1);
        @(posedge clock);
        #1 bus.data_valid = 1'b0;
        capture(8'h99, 2'd0, 1'b0, 1'b0, "f99", 0, 1);

`ifdef UART_TX_BUFFER_EN
        offer(8'h12, 2'd0, 1'b0);
        capture(8'h12, 2'd0, 1'b0, 1'b0, "b12", 3, 1);
        check("b_nogap", txd, 0);
        capture(8'h34, 2'd0, 1'b0, 1'b0, "b34", 0, 2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
